// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small byte FIFO feeding a 16x-oversampled
// serial framer (start bit, DBIT data bits LSB first, stop bit, no parity).
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   i_tick          16x baud tick, one clk wide
//   i_wr            write strobe, accepted when o_full is low
//   i_data          byte to enqueue
//   o_tx            serial line, idle high (registered)
//   o_full          FIFO holds FIFO_DEPTH bytes (registered)
//   o_busy          framer is not idle (registered)
//   o_tx_done_tick  one-clk pulse at the end of each stop bit (registered)
module uart_tx_buffered #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_tick,
  input  logic            i_wr,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_full,
  output logic            o_busy,
  output logic            o_tx_done_tick
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TICK_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int unsigned BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [DBIT-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             wr_en, pop;

  // Framer state
  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DBIT-1:0]   shift_q, shift_d;

  // Registered outputs
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // A write while full is dropped even if the framer pops in the same cycle.
  assign wr_en = i_wr & ~full_q;
  assign pop   = (state_q == ST_IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  // Storage array carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // State and datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; cycles without i_tick hold everything.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == TICK_W'(15)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_W'(15)) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_W'(DBIT - 1)) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_W'(SB_TICK - 1)) begin
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line lines up
  // with the state it belongs to; IDLE drives high, so the gap between
  // back-to-back frames never dips low.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && i_tick && (tick_q == TICK_W'(SB_TICK - 1));
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_full         = full_q;
  assign o_busy         = busy_q;
  assign o_tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: directed writes push expected bytes into a
// scoreboard queue; a tick-counting receiver monitor decodes the line and
// checks each frame, its bit timing and its done pulse against the queue.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_full;
  logic       o_busy;
  logic       o_tx_done_tick;

  uart_tx_buffered #(
    .DBIT      (8),
    .SB_TICK   (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_tick        (i_tick),
    .i_wr          (i_wr),
    .i_data        (i_data),
    .o_tx          (o_tx),
    .o_full        (o_full),
    .o_busy        (o_busy),
    .o_tx_done_tick(o_tx_done_tick)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];
  int         gap_q[$];
  int         tick_mode = 0;
  int         rx_cnt = 0;
  bit         rx_act = 1'b0;
  int         n_done = 0;
  int         gaps_tbl[8] = '{1, 3, 7, 2, 5, 1, 4, 6};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud tick source: every 4 clk, or irregular 1..7 clk spacing.
  initial begin
    int left;
    int gidx;
    left   = 0;
    gidx   = 0;
    i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (left == 0) begin
        i_tick = 1'b1;
        if (tick_mode == 0) begin
          left = 3;
        end else begin
          left = gaps_tbl[gidx] - 1;
          gidx = (gidx + 1) % 8;
        end
      end else begin
        i_tick = 1'b0;
        left--;
      end
    end
  end

  // Receiver monitor: counts consumed ticks from the start edge, samples
  // mid-bit, checks each bit holds for 16 ticks and done lands on tick 160.
  initial begin
    int         n;
    int         b;
    int         mcyc;
    int         last_done;
    bit         have_done;
    logic       cur;
    logic [7:0] data;
    logic [7:0] exp_b;
    mcyc      = 0;
    last_done = 0;
    have_done = 1'b0;
    cur       = 1'b1;
    data      = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst) begin
        rx_act    = 1'b0;
        rx_cnt    = 0;
        have_done = 1'b0;
        continue;
      end
      if (o_tx_done_tick) begin
        n_done++;
        check("done_in_frame", 32'(rx_act), 32'd1);
        check("done_tick_pos", rx_cnt, 160);
        rx_act    = 1'b0;
        last_done = mcyc;
        have_done = 1'b1;
      end
      if (!rx_act && o_tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        if (have_done) gap_q.push_back(mcyc - last_done);
      end
      if (rx_act && i_tick) begin
        rx_cnt++;
        n = rx_cnt;
        if (((n - 1) % 16) == 0) cur = o_tx;
        else if (n <= 160) check("bit_stable", 32'(o_tx), 32'(cur));
        if ((n % 16) == 8) begin
          b = n / 16;
          if (b == 0) begin
            check("start_bit", 32'(o_tx), 32'd0);
          end else if (b <= 8) begin
            data[b-1] = o_tx;
          end else if (b == 9) begin
            check("stop_bit", 32'(o_tx), 32'd1);
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rx_byte: got %02h with nothing expected", data);
            end else begin
              exp_b = sb_q.pop_front();
              check("rx_byte", 32'(data), 32'(exp_b));
            end
          end
        end
        if (n > 170) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_missing: got no done pulse after %0d ticks, required one at 160", n);
          rx_act = 1'b0;
        end
      end
    end
  end

  // Write one byte from idle and check first-bit latency.
  task automatic send_first(input logic [7:0] d);
    @(posedge clk);
    #1;
    i_wr   = 1'b1;
    i_data = d;
    sb_q.push_back(d);
    @(posedge clk);
    #1;
    i_wr = 1'b0;
    check("lat_before", 32'(o_tx), 32'd1);
    @(posedge clk);
    #1;
    check("lat_start", 32'(o_tx), 32'd0);
    check("lat_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic write_raw(input logic [7:0] d);
    @(posedge clk);
    #1;
    i_wr   = 1'b1;
    i_data = d;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || o_busy) && g < 8000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 8000) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, required idle", o_busy, sb_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int g;
    rst    = 1'b1;
    i_wr   = 1'b0;
    i_data = '0;
    #1;
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_done", 32'(o_tx_done_tick), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle line after reset with no writes
    repeat (1000) begin
      @(negedge clk);
      check("idle_tx", 32'(o_tx), 32'd1);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_full", 32'(o_full), 32'd0);
    end

    // Single bytes at a regular tick rate
    d0 = n_done;
    send_first(8'h01);
    wait_idle();
    check("done_cnt_01", n_done - d0, 1);
    d0 = n_done;
    send_first(8'hA5);
    wait_idle();
    check("done_cnt_a5", n_done - d0, 1);

    // Six consecutive writes: five accepted, sixth dropped while full
    d0 = n_done;
    gap_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      i_wr   = 1'b1;
      i_data = 8'h10 + 8'(i);
      check("full_at_wr", 32'(o_full), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) sb_q.push_back(8'h10 + 8'(i));
      @(posedge clk);
      #1;
    end
    i_wr = 1'b0;
    check("full_after_drop", 32'(o_full), 32'd1);
    wait_idle();
    check("done_cnt_fifo", n_done - d0, 5);
    check("gap_count", gap_q.size(), 5);
    for (int k = 1; k < 5; k++) begin
      if (k < gap_q.size()) check("idle_gap", gap_q[k], 1);
    end

    // Reset during data bit 3 with further bytes queued
    d0 = n_done;
    send_first(8'hFF);
    write_raw(8'h77);
    write_raw(8'h66);
    g = 0;
    while (rx_cnt < 72 && g < 4000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 4000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_bit3: got tick count %0d, required 72", rx_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_tx", 32'(o_tx), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_full", 32'(o_full), 32'd0);
    check("abort_done", 32'(o_tx_done_tick), 32'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) begin
      @(negedge clk);
      check("discard_busy", 32'(o_busy), 32'd0);
      check("discard_tx", 32'(o_tx), 32'd1);
    end
    check("abort_no_done", n_done - d0, 0);
    d0 = n_done;
    send_first(8'h3C);
    wait_idle();
    check("done_cnt_3c", n_done - d0, 1);

    // Irregular tick spacing
    tick_mode = 1;
    d0 = n_done;
    send_first(8'h5A);
    wait_idle();
    check("done_cnt_5a", n_done - d0, 1);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter: DBIT, default 8, data bits per frame.
REQ-002 Parameter: SB_TICK, default 16, stop-bit length in i_tick pulses.
REQ-003 Parameter: FIFO_DEPTH, default 4, byte FIFO depth, power of two.
REQ-004 Port: clk  input  1  single system clock, rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: i_tick  input  1  16x-oversampling baud tick, one clk wide, from the shared baud generator.
REQ-007 Port: i_wr  input  1  write strobe; enqueues i_data when accepted.
REQ-008 Port: i_data  input  DBIT  byte to transmit.
REQ-009 Port: o_tx  output  1  serial line, idle high.
REQ-010 Port: o_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 Port: o_busy  output  1  FSM not in IDLE.
REQ-012 Port: o_tx_done_tick  output  1  one-clk pulse at end of each frame's stop bit.

Function
REQ-013 Frame format SHALL be 8N1 by default: start bit 0, DBIT data bits LSB first, one stop bit 1; no parity.
REQ-014 Write SHALL be accepted when i_wr=1 and o_full=0 at the rising edge; write with o_full=1 SHALL be dropped, even if a pop occurs in the same cycle.
REQ-015 FIFO SHALL be first-in first-out, with circular read/write pointers of log2(FIFO_DEPTH) bits; a simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, with an internal tick counter (0..15), bit counter (0..DBIT-1) and DBIT-bit shift register.
REQ-017 IDLE: with FIFO non-empty, SHALL pop head into the shift register, clear the tick counter and enter START at the next edge; with FIFO empty, SHALL stay in IDLE with o_tx=1.
REQ-018 START: o_tx=0; on each i_tick, the tick counter SHALL increment; on the i_tick with count=15, SHALL clear the tick and bit counters and enter DATA.
REQ-019 DATA: o_tx=shift[0]; on the i_tick with count=15, SHALL shift right by one and increment the bit counter; if the bit counter = DBIT-1, SHALL enter STOP instead.
REQ-020 STOP: o_tx=1; on the i_tick with count=SB_TICK-1, SHALL assert o_tx_done_tick for exactly that clk cycle and return to IDLE.
REQ-021 Clock cycles without i_tick SHALL hold all counters and state.
REQ-022 o_tx SHALL be registered (glitch-free).
REQ-023 Latency: a byte written into an empty FIFO with FSM in IDLE at edge k SHALL drive o_tx=0 from edge k+1.
REQ-024 Frame length SHALL be (1+DBIT)*16+SB_TICK i_tick pulses, i.e. 160 for defaults.
REQ-025 Back-to-back: with FIFO non-empty at stop end, the next start bit SHALL begin exactly one clk after IDLE is re-entered; the line SHALL not glitch low during that cycle.
REQ-026 o_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-027 rst=1 SHALL immediately, without a clock, force: state IDLE, o_tx=1, o_busy=0, o_tx_done_tick=0, o_full=0, FIFO empty, all counters and the shift register 0.
REQ-028 rst asserted mid-frame SHALL abort the frame; bytes in the FIFO SHALL be discarded; no o_tx_done_tick SHALL be emitted for the aborted frame.
REQ-029 After rst release, the first accepted write SHALL be transmitted per REQ-023.

Verification
REQ-030 Reset: rst=1, then release with no writes for 1000 clk -> o_tx=1, o_busy=0, o_full=0 throughout.
REQ-031 Single byte: i_tick every 4 clk, write 0x01 -> o_tx sequence 0,1,0,0,0,0,0,0,0,1, each bit 16 ticks (64 clk); one o_tx_done_tick at the 160th tick.
REQ-032 Pattern check: write 0xA5 -> data bits 1,0,1,0,0,1,0,1 LSB first; a receiver model decodes 0xA5.
REQ-033 FIFO full: write 0x10..0x15 on 6 consecutive clk from idle -> 0x10..0x14 accepted (first popped at edge 1), o_full=1 on the 6th write, 0x15 dropped; line carries 5 contiguous frames with exactly one idle clk between frames and 5 done pulses.
REQ-034 Reset mid-frame: write 0xFF, assert rst during DATA bit 3 -> o_tx=1 in the same cycle, no done pulse, FIFO empty; a subsequent write of 0x3C is transmitted correctly.
REQ-035 Tick gaps: i_tick with irregular spacing (1-7 clk) -> bit boundaries still fall exactly every 16 ticks; byte 0x5A is decoded correctly.
